// File: rtl/mac_multi_package.sv
// Shared types and helpers for the multi-stream MAC control FSM.
package mac_multi_package;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    COMPUTE,
    UPDATEIDX,
    WAIT,
    DRAIN
  } state_e;

  // Bit position of stream idx inside a flattened per-stream address bus.
  function automatic int unsigned stream_lsb(input int unsigned idx);
    return idx * ADDR_W;
  endfunction

endpackage

// File: rtl/mac_fsm_watchdog.sv
// Cycle counter that flags a control state held for TIMEOUT consecutive cycles.
module mac_fsm_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  input  logic restart,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || restart || !count_en) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = count_en && (cnt == LAST);

endmodule

// File: rtl/mac_fsm_multi.sv
// Control FSM sequencing streamer, engine and ucode across the iterations of a job.
// Optional state watchdog is built when MAC_FSM_TIMEOUT_EN is defined.
module mac_fsm_multi
  import mac_multi_package::*;
#(
  parameter int unsigned N_SRC   = 3,
  parameter int unsigned N_SINK  = 1,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned ACC_IDX = 2,
  parameter int unsigned ITER_W  = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic                                start_i,
  input  logic [LEN_W-1:0]                    len_i,
  input  logic                                simple_mul_i,
  input  logic [N_SRC+N_SINK-1:0]             stream_en_i,
  input  logic [(N_SRC+N_SINK)*ADDR_W-1:0]    base_addr_i,
  input  logic [(N_SRC+N_SINK)*ADDR_W-1:0]    offs_i,
  input  logic [N_SRC+N_SINK-1:0]             ready_start_i,
  output logic [N_SRC+N_SINK-1:0]             req_start_o,
  output logic [(N_SRC+N_SINK)*ADDR_W-1:0]    base_addr_o,
  input  logic [LEN_W-1:0]                    eng_cnt_i,
  output logic                                eng_start_o,
  output logic                                eng_clear_o,
  output logic                                eng_enable_o,
  input  logic                                ucode_valid_i,
  input  logic                                ucode_done_i,
  output logic                                ucode_enable_o,
  output logic                                ucode_clear_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [ITER_W-1:0]                   iter_cnt_o,
  output logic                                error_o
);

  localparam int unsigned N_STREAM = N_SRC + N_SINK;

  state_e              state;
  state_e              state_next;
  logic [N_STREAM-1:0] en_q;
  logic [N_STREAM-1:0] acc_mask;
  logic [ITER_W-1:0]   iter_cnt;
  logic                all_ready;
  logic                launch;
  logic                job_done;
  logic                expire;

  // Offsets are bit offsets from the ucode; convert to bytes before adding.
  for (genvar i = 0; i < N_STREAM; i++) begin : g_addr
    assign base_addr_o[stream_lsb(i) +: ADDR_W] =
      base_addr_i[stream_lsb(i) +: ADDR_W] + (offs_i[stream_lsb(i) +: ADDR_W] >> 3);
  end

  always_comb begin
    acc_mask          = '0;
    acc_mask[ACC_IDX] = simple_mul_i;
  end

  assign all_ready = &(ready_start_i | ~en_q);

  assign launch = !clear_i && !expire && all_ready &&
                  (state == START || state == WAIT ||
                   (state == UPDATEIDX && ucode_valid_i && !ucode_done_i));

  assign job_done = !clear_i && !expire && all_ready && (state == DRAIN);

`ifdef MAC_FSM_TIMEOUT_EN
  logic err;

  mac_fsm_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (clear_i),
    .count_en (state == WAIT || state == COMPUTE || state == DRAIN),
    .restart  (state_next != state),
    .expire   (expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if (clear_i) begin
      err <= 1'b0;
    end else if (expire) begin
      err <= 1'b1;
    end else if (state == IDLE && start_i) begin
      err <= 1'b0;
    end
  end

  assign error_o = err;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign expire  = 1'b0;
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start_i) state_next = (len_i == '0) ? DRAIN : START;
      START:     state_next = all_ready ? COMPUTE : WAIT;
      COMPUTE:   if (eng_cnt_i == len_i) state_next = UPDATEIDX;
      UPDATEIDX: begin
        if (ucode_valid_i) begin
          if (ucode_done_i) state_next = DRAIN;
          else              state_next = all_ready ? COMPUTE : WAIT;
        end
      end
      WAIT:      if (all_ready) state_next = COMPUTE;
      DRAIN:     if (all_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (clear_i || expire) state_next = IDLE;
  end

  always_comb begin
    req_start_o    = '0;
    eng_start_o    = 1'b0;
    eng_clear_o    = 1'b1;
    eng_enable_o   = 1'b1;
    ucode_enable_o = 1'b0;
    ucode_clear_o  = 1'b0;
    done_o         = job_done;
    case (state)
      IDLE:      ucode_clear_o = 1'b1;
      COMPUTE:   eng_clear_o = 1'b0;
      UPDATEIDX: ucode_enable_o = !ucode_valid_i;
      WAIT, DRAIN: begin
        eng_clear_o  = 1'b0;
        eng_enable_o = 1'b0;
      end
      default: ;
    endcase
    if (launch) begin
      req_start_o = en_q;
      eng_start_o = 1'b1;
      eng_clear_o = 1'b0;
    end
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q <= '0;
    end else if (clear_i) begin
      en_q <= '0;
    end else if (state == IDLE && start_i) begin
      en_q <= stream_en_i & ~acc_mask;
    end
  end

  // Saturates rather than wrapping so a very long job never reports zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iter_cnt <= '0;
    end else if (clear_i || state == IDLE) begin
      iter_cnt <= '0;
    end else if (launch && iter_cnt != '1) begin
      iter_cnt <= iter_cnt + 1'b1;
    end
  end

  assign iter_cnt_o = iter_cnt;

endmodule

// File: doc/mac_fsm_multi.md
Name: mac_fsm_multi

Overview:
Parametrised successor of the MAC control FSM, for HWPE accelerators with N_SRC source streams and N_SINK sink streams.
- Sequences stream start requests, engine start/clear/enable and microcode index updates across many iterations.
- Supports a per-job stream-enable mask and a DRAIN phase before completion.
- Sits between the slave/regfile, the streamer, the engine and the ucode block.

Parameters:
N_SRC, 3, number of source streams (indices 0..N_SRC-1)
N_SINK, 1, number of sink streams (indices N_SRC..N_STREAM-1)
LEN_W, 16, width of job length and engine counter
ACC_IDX, 2, source index disabled automatically in simple_mul mode
ITER_W, 16, width of iteration counter
TIMEOUT, 1024, watchdog cycles (optional feature only)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clear_i  in  1  synchronous clear, same effect as reset
start_i  in  1  job start pulse from slave
len_i  in  LEN_W  elements per iteration
simple_mul_i  in  1  mode: disable stream ACC_IDX
stream_en_i  in  N_STREAM  per-stream enable mask, sampled on start
base_addr_i  in  N_STREAM*32  regfile base addresses
offs_i  in  N_STREAM*32  ucode bit offsets
ready_start_i  in  N_STREAM  streamer ready_start flags
req_start_o  out  N_STREAM  one-cycle stream start requests
base_addr_o  out  N_STREAM*32  effective byte addresses
eng_cnt_i  in  LEN_W  engine element counter
eng_start_o, eng_clear_o, eng_enable_o  out  1 each  engine control
ucode_valid_i, ucode_done_i  in  1 each  ucode flags
ucode_enable_o, ucode_clear_o  out  1 each  ucode control
busy_o  out  1  state != IDLE
done_o  out  1  job-complete pulse
iter_cnt_o  out  ITER_W  iterations launched in current job
error_o  out  1  watchdog flag (0 without macro)

Behaviour:
- N_STREAM = N_SRC + N_SINK.
- Reset/clear: state IDLE, en_q = 0, iter_cnt_o = 0, error_o = 0.
  - During reset: eng_clear_o = 1, eng_enable_o = 1, ucode_clear_o = 1; all other outputs 0.
  - clear_i beats start_i in the same cycle. Reset mid-job aborts with no done_o.
- base_addr_o[i] = base_addr_i[i] + (offs_i[i] >> 3), mod 2^32, combinational.
- en_q is registered on start_i as stream_en_i, with bit ACC_IDX cleared if simple_mul_i.
- all_ready = &(ready_start_i | ~en_q).
- launch: req_start_o = en_q for one cycle, eng_start_o = 1, eng_clear_o = 0, iter_cnt_o += 1 (saturating).
- Outputs are combinational from state and inputs (Mealy).
- Default outputs: eng_clear_o = 1, eng_enable_o = 1, others 0.
- States:
  - IDLE: ucode_clear_o = 1; iter_cnt_o cleared.
    - start_i and len_i == 0 -> DRAIN.
    - start_i -> START.
  - START: all_ready -> launch, COMPUTE; else WAIT.
  - COMPUTE: eng_clear_o = 0; eng_cnt_i == len_i -> UPDATEIDX.
  - UPDATEIDX:
    - !ucode_valid_i -> ucode_enable_o = 1, stay.
    - else ucode_done_i -> DRAIN.
    - else all_ready -> launch, COMPUTE.
    - else WAIT.
  - WAIT: eng_clear_o = 0, eng_enable_o = 0; all_ready -> launch (including eng_start_o), COMPUTE.
  - DRAIN: eng_clear_o = 0, eng_enable_o = 0; all_ready -> done_o = 1, IDLE.
- Disabled streams never receive req_start_o, and their ready_start_i is ignored.
- start_i is ignored outside IDLE.

Optional Feature:
MAC_FSM_TIMEOUT_EN
- With macro:
  - A counter increments each cycle in WAIT, COMPUTE or DRAIN and resets on any state change.
  - At TIMEOUT the FSM goes to IDLE, sets sticky error_o, and does not pulse done_o.
  - error_o is cleared by the next start_i, by clear_i or by reset.
- Without macro: error_o tied 0; no counter.

Decomposition:
- Package mac_multi_package: state enum (IDLE, START, COMPUTE, UPDATEIDX, WAIT, DRAIN), ADDR_W = 32, helper function for stream-index offsets.
- Sub-module mac_fsm_watchdog (timeout counter), instantiated only under the macro.

Test Plan:
- N_SRC=3, N_SINK=1, len_i=4, all ready, ucode_done_i after 2 valid -> req_start_o=4'b1111 twice, iter_cnt_o=2, done_o single pulse, busy_o low after.
- simple_mul_i=1, stream_en_i=4'b1111 -> req_start_o=4'b1011; ready_start_i[2]=0 does not block launch.
- ready_start_i[3] low 5 cycles after start -> WAIT held 5 cycles, eng_enable_o=0; launch with eng_start_o=1 on the cycle ready rises.
- len_i=0 with start_i -> no req_start_o, done_o within 2 cycles.
- base_addr_i[1]=0x1000, offs_i[1]=0x40 -> base_addr_o[1]=0x1008; base 0xFFFFFFFC, offs 0x40 -> 0x00000004.
- rst_i asserted mid-COMPUTE -> IDLE, no done_o, outputs at reset values. With MAC_FSM_TIMEOUT_EN, stuck in WAIT for TIMEOUT cycles -> error_o=1, IDLE.
